// File: rtl/aict_if.sv
// Core request port, SRAM port and interrupt lines of the AICT controller.
// master = core/SRAM side, slave = controller.
interface aict_if #(
  parameter int NUM_IRQ = 24
) ();
  localparam int VW = $clog2(NUM_IRQ);

  logic               valid;
  logic               ready;
  logic [31:0]        addr;
  logic [31:0]        dtw;
  logic [31:0]        dtr;
  logic               rw;
  logic               sval;
  logic               srdy;
  logic [31:0]        saddr;
  logic [31:0]        sdtw;
  logic [31:0]        sdtr;
  logic               srw;
  logic [NUM_IRQ-1:0] irq_in;
  logic               ack;
  logic               intrq;
  logic               nmi;
  logic [VW-1:0]      vec;
  logic [31:0]        handler;

  modport master (
    output valid, addr, dtw, rw, srdy, sdtr, irq_in, ack,
    input  ready, dtr, sval, saddr, sdtw, srw, intrq, nmi, vec, handler
  );

  modport slave (
    input  valid, addr, dtw, rw, srdy, sdtr, irq_in, ack,
    output ready, dtr, sval, saddr, sdtw, srw, intrq, nmi, vec, handler
  );
endinterface

// File: rtl/aict_ctrl.sv
// AICT: edge-triggered interrupt controller with a relocatable register window;
// other traffic passes to SRAM. Define AICT_SYNC_EN to add a 2-flop irq synchroniser.
module aict_ctrl #(
  parameter int          NUM_IRQ  = 24,
  parameter int          NUM_NMI  = 2,
  parameter logic [31:0] BASE_RST = 32'hFFFF_0000
) (
  input logic   clk,
  input logic   reset,
  aict_if.slave bus
);
  localparam int VW          = $clog2(NUM_IRQ);
  localparam int NUM_REGS    = NUM_IRQ + 3;
  localparam int ENABLE_IDX  = NUM_IRQ + 1;
  localparam int PENDING_IDX = NUM_IRQ + 2;

  function automatic logic [NUM_IRQ-1:0] nmi_mask_f();
    logic [NUM_IRQ-1:0] m;
    for (int i = 0; i < NUM_IRQ; i++) m[i] = (i < NUM_NMI);
    return m;
  endfunction
  localparam logic [NUM_IRQ-1:0] NMI_MASK = nmi_mask_f();

  typedef enum logic {IDLE, WACK} state_e;

  state_e             state_q, state_d;
  logic [29:0]        base_q, base_d;
  logic [31:0]        handler_q [NUM_IRQ];
  logic [31:0]        handler_d [NUM_IRQ];
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] irq_s, rise, active;
  logic [29:0]        addr_w, word_idx;
  logic               win_hit, wack, wr_en, intrq_c;
  logic [31:0]        reg_rdata;
  logic [VW-1:0]      vec_c;

`ifdef AICT_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  assign sync1_d = bus.irq_in;
  assign sync2_d = sync1_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
  assign irq_s = sync2_q;
`else
  assign irq_s = bus.irq_in;
`endif

  // Base is word aligned, so the window compare works on word addresses.
  assign addr_w   = bus.addr[31:2];
  assign word_idx = addr_w - base_q;
  assign win_hit  = (addr_w >= base_q) &&
                    ({1'b0, addr_w} < ({1'b0, base_q} + 31'(NUM_REGS)));
  assign wack     = (state_q == WACK) && !reset;

  // The write being acknowledged completes here even if it just moved the window.
  assign bus.ready = wack ? 1'b1 : (win_hit ? ~bus.rw : bus.srdy);
  assign bus.sval  = bus.valid & ~win_hit & ~wack;
  assign bus.dtr   = win_hit ? reg_rdata : bus.sdtr;
  assign bus.saddr = bus.addr;
  assign bus.sdtw  = bus.dtw;
  assign bus.srw   = bus.rw;

  always_comb begin
    reg_rdata = 32'h0;
    if (word_idx == 30'd0) reg_rdata = {base_q, 2'b00};
    else if (word_idx == 30'(ENABLE_IDX)) reg_rdata = 32'(enable_q);
    else if (word_idx == 30'(PENDING_IDX)) reg_rdata = 32'(pending_q);
    for (int i = 0; i < NUM_IRQ; i++)
      if (word_idx == 30'(i + 1)) reg_rdata = handler_q[i];
  end

  assign rise    = irq_s & ~prev_q;
  assign prev_d  = irq_s;
  assign active  = pending_q & (enable_q | NMI_MASK);
  assign intrq_c = |active;

  always_comb begin
    vec_c = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (active[i]) vec_c = VW'(i);
  end

  assign bus.intrq   = intrq_c;
  assign bus.vec     = vec_c;
  assign bus.nmi     = intrq_c & NMI_MASK[vec_c];
  assign bus.handler = handler_q[vec_c];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    state_d   = state_q;
    base_d    = base_q;
    handler_d = handler_q;
    enable_d  = enable_q;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: if (bus.valid && bus.rw && win_hit) begin
        wr_en   = 1'b1;
        state_d = WACK;
      end
      WACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      if (word_idx == 30'd0) base_d = bus.dtw[31:2];
      else if (word_idx == 30'(ENABLE_IDX)) enable_d = bus.dtw[NUM_IRQ-1:0];
      for (int i = 0; i < NUM_IRQ; i++)
        if (word_idx == 30'(i + 1)) handler_d[i] = bus.dtw;
    end

    // Clears first, then new edges, so a coincident rise always keeps the bit set.
    pending_d = pending_q;
    if (bus.ack && intrq_c) pending_d[vec_c] = 1'b0;
    if (wr_en && word_idx == 30'(PENDING_IDX)) pending_d = pending_d & ~bus.dtw[NUM_IRQ-1:0];
    pending_d = pending_d | rise;
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= BASE_RST[31:2];
      enable_q  <= '0;
      pending_q <= '0;
      prev_q    <= '0;
      // NOTE: the handler table is software-visible and must read 0 after reset, so it is reset.
      for (int i = 0; i < NUM_IRQ; i++) handler_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      prev_q    <= prev_d;
      handler_q <= handler_d;
    end
  end
endmodule

// File: tb/tb_aict_ctrl.sv
// Directed scoreboard bench for aict_ctrl: register window, write handshake,
// interrupt priority/ack, W1C, window relocation and reset during a write.
module tb_aict_ctrl;
  localparam logic [31:0] BASE0  = 32'hFFFF_0000;
  localparam logic [31:0] BASE1  = 32'h0000_8000;
  localparam logic [31:0] OFF_EN = 32'h64;
  localparam logic [31:0] OFF_PD = 32'h68;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] d;
  logic        r, s;

  aict_if #(.NUM_IRQ(24)) bus ();

  aict_ctrl #(.NUM_IRQ(24), .NUM_NMI(2), .BASE_RST(BASE0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=0x%0h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] dat, output logic rdy, output logic sv);
    bus.valid = 1'b1; bus.rw = 1'b0; bus.addr = a;
    @(negedge clk);
    dat = bus.dtr; rdy = bus.ready; sv = bus.sval;
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] dat, input string tag);
    int n;
    bus.valid = 1'b1; bus.rw = 1'b1; bus.addr = a; bus.dtw = dat;
    push({tag, "_latency"}, 32'd1);
    n = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && n < 8) begin
      @(posedge clk); #1; @(negedge clk);
      n++;
    end
    check(32'(n));
    @(posedge clk); #1;
    bus.valid = 1'b0;
    push({tag, "_single_pulse"}, 32'd0);
    @(negedge clk);
    check({31'b0, bus.ready});
    @(posedge clk); #1;
    bus.rw = 1'b0;
  endtask

  task automatic irq_chk(input string tag, input logic ei, input logic en, input logic [4:0] ev);
    push({tag, "_intrq"}, {31'b0, ei});
    push({tag, "_nmi"}, {31'b0, en});
    push({tag, "_vec"}, {27'b0, ev});
    @(negedge clk);
    check({31'b0, bus.intrq});
    check({31'b0, bus.nmi});
    check({27'b0, bus.vec});
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e_d,
                        input logic e_r, input logic e_s);
    push({tag, "_dtr"}, e_d);
    push({tag, "_ready"}, {31'b0, e_r});
    push({tag, "_sval"}, {31'b0, e_s});
    rd(a, d, r, s);
    check(d);
    check({31'b0, r});
    check({31'b0, s});
  endtask

  initial begin
    bus.valid = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.dtw = '0;
    bus.srdy = 1'b0; bus.sdtr = 32'h0000_CAFE; bus.irq_in = '0; bus.ack = 1'b0;
    idle(3);
    reset = 1'b0;
    irq_chk("reset", 1'b0, 1'b0, 5'd0);

    // Window reads, boundaries and SRAM pass-through.
    rd_chk("t1_base", BASE0, BASE0, 1'b1, 1'b0);
    rd_chk("t1_pending_last", BASE0 + OFF_PD, 32'h0, 1'b1, 1'b0);
    bus.srdy = 1'b1;
    rd_chk("t1_end_excl", BASE0 + 32'h6C, 32'h0000_CAFE, 1'b1, 1'b1);
    rd_chk("t1_sram_70", BASE0 + 32'h70, 32'h0000_CAFE, 1'b1, 1'b1);
    bus.srdy = 1'b0;
    rd_chk("t1_below", BASE0 - 32'h4, 32'h0000_CAFE, 1'b0, 1'b1);

    // Handler write with one-cycle acknowledge.
    wr(BASE0 + 32'h14, 32'h0000_1234, "t2_wr_h4");
    rd_chk("t2_rdback", BASE0 + 32'h17, 32'h0000_1234, 1'b1, 1'b0);

    // Priority between enabled lines 4 and 5.
    wr(BASE0 + OFF_EN, 32'h30, "t3_en");
    bus.irq_in[5] = 1'b1; idle(1);
    bus.irq_in[5] = 1'b0; bus.irq_in[4] = 1'b1; idle(1);
    bus.irq_in[4] = 1'b0; idle(4);
    push("t3_handler", 32'h0000_1234);
    @(negedge clk); check(bus.handler); @(posedge clk); #1;
    irq_chk("t3_first", 1'b1, 1'b0, 5'd4);
    bus.ack = 1'b1; idle(1); bus.ack = 1'b0;
    irq_chk("t3_second", 1'b1, 1'b0, 5'd5);
    bus.ack = 1'b1; idle(1); bus.ack = 1'b0;
    irq_chk("t3_none", 1'b0, 1'b0, 5'd0);

    // NMI ignores ENABLE; maskable line waits for its enable.
    wr(BASE0 + OFF_EN, 32'h0, "t4_en0");
    bus.irq_in[1] = 1'b1; idle(4);
    irq_chk("t4_nmi", 1'b1, 1'b1, 5'd1);
    bus.ack = 1'b1; idle(1); bus.ack = 1'b0;
    irq_chk("t4_nmi_acked", 1'b0, 1'b0, 5'd0);
    bus.irq_in[7] = 1'b1; idle(4);
    irq_chk("t4_masked", 1'b0, 1'b0, 5'd0);
    rd_chk("t4_pending", BASE0 + OFF_PD, 32'h80, 1'b1, 1'b0);
    wr(BASE0 + OFF_EN, 32'h80, "t4_en7");
    irq_chk("t4_unmasked", 1'b1, 1'b0, 5'd7);
    bus.ack = 1'b1; idle(1); bus.ack = 1'b0;
    irq_chk("t4_acked", 1'b0, 1'b0, 5'd0);
    bus.irq_in = '0; idle(2);

    // Ack and W1C each coincident with a new rise on the same line.
    wr(BASE0 + OFF_EN, 32'h08, "t5_en");
    bus.irq_in[3] = 1'b1; idle(1); bus.irq_in[3] = 1'b0; idle(4);
    irq_chk("t5_pend3", 1'b1, 1'b0, 5'd3);
    bus.ack = 1'b1; bus.irq_in[3] = 1'b1; idle(1);
    bus.ack = 1'b0; bus.irq_in[3] = 1'b0; idle(4);
    irq_chk("t5_ack_vs_rise", 1'b1, 1'b0, 5'd3);
    bus.irq_in[3] = 1'b1;
    wr(BASE0 + OFF_PD, 32'h08, "t5_w1c_rise");
    bus.irq_in[3] = 1'b0; idle(4);
    rd_chk("t5_rise_wins", BASE0 + OFF_PD, 32'h08, 1'b1, 1'b0);
    wr(BASE0 + OFF_PD, 32'h08, "t5_w1c");
    rd_chk("t5_cleared", BASE0 + OFF_PD, 32'h0, 1'b1, 1'b0);
    irq_chk("t5_idle", 1'b0, 1'b0, 5'd0);

    // Window relocation.
    wr(BASE0, BASE1, "t6_base");
    rd_chk("t6_old_win", BASE0, 32'h0000_CAFE, 1'b0, 1'b1);
    wr(BASE1 + 32'h4, 32'hA5A5_0001, "t6_wr_h0");
    rd_chk("t6_h0", BASE1 + 32'h4, 32'hA5A5_0001, 1'b1, 1'b0);
    rd_chk("t6_newbase", BASE1, BASE1, 1'b1, 1'b0);

    // Reset while the write acknowledge is pending.
    bus.valid = 1'b1; bus.rw = 1'b1; bus.addr = BASE1 + 32'h8; bus.dtw = 32'h0BAD_0BAD;
    idle(1);
    reset = 1'b1;
    push("t6_rst_no_ready", 32'd0);
    @(negedge clk); check({31'b0, bus.ready});
    @(posedge clk); #1;
    reset = 1'b0; bus.valid = 1'b0; bus.rw = 1'b0;
    rd_chk("t6_rst_base", BASE0, BASE0, 1'b1, 1'b0);
    rd_chk("t6_rst_h0", BASE0 + 32'h4, 32'h0, 1'b1, 1'b0);
    rd_chk("t6_rst_h1", BASE0 + 32'h8, 32'h0, 1'b1, 1'b0);
    irq_chk("t6_rst_irq", 1'b0, 1'b0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
